// File: rtl/aes_pkg.sv
// Shared AES constants and types: round-key type, key-schedule FSM states,
// round constants and the forward S-box (also used by the encrypt datapath).
package aes_pkg;

  localparam int NR = 14;
  localparam int NK = 8;

  typedef logic [127:0] round_key_t;

  typedef enum logic [1:0] {
    KS_IDLE,
    KS_EXPAND,
    KS_DONE
  } key_sched_state_e;

  localparam logic [7:0] RCON [0:6] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/aes_sub_word.sv
// Combinational SubWord: forward S-box applied to each byte of a 32-bit word.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] subst
);

  assign subst = {SBOX[word[31:24]], SBOX[word[23:16]], SBOX[word[15:8]], SBOX[word[7:0]]};

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Iterative AES-256 key expansion, one 128-bit round key per cycle, all 15 kept in registers.
// Optional KEY_SCHED_ZEROIZE_EN adds a zeroize input that wipes key material like rst.
module aes_key_schedule_seq
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [255:0]     key_in,
  input  logic             key_valid,
  output logic             key_ready,
  output round_key_t       key_out [0:NR],
  output logic             keys_valid,
  input  logic [3:0]       rk_addr,
  output round_key_t       rk_data
`ifdef KEY_SCHED_ZEROIZE_EN
  ,
  input  logic             zeroize
`endif
);

  key_sched_state_e state_q, state_d;
  logic [3:0]  cnt;
  logic [2:0]  rcon_idx;
  logic        accept;
  logic        wipe;
  logic [31:0] prev_last;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] t;
  logic [31:0] w0, w1, w2, w3;
  round_key_t  older;

`ifdef KEY_SCHED_ZEROIZE_EN
  assign wipe = zeroize;
`else
  assign wipe = 1'b0;
`endif

  // Control: FSM next state and handshake.
  always_comb begin
    state_d   = state_q;
    key_ready = 1'b0;
    accept    = 1'b0;
    case (state_q)
      KS_IDLE, KS_DONE: begin
        key_ready = 1'b1;
        accept    = key_valid;
        if (key_valid) state_d = KS_EXPAND;
      end
      KS_EXPAND: begin
        if (cnt == 4'(NR)) state_d = KS_DONE;
      end
      default: state_d = KS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || wipe) state_q <= KS_IDLE;
    else             state_q <= state_d;
  end

  // Datapath: even slots rotate and add rcon, odd slots only substitute.
  assign prev_last = key_out[cnt - 4'd1][31:0];
  assign older     = key_out[cnt - 4'd2];
  assign sub_in    = cnt[0] ? prev_last : {prev_last[23:0], prev_last[31:24]};

  aes_sub_word u_sub_word (
    .word  (sub_in),
    .subst (sub_out)
  );

  assign t  = cnt[0] ? sub_out : (sub_out ^ {RCON[rcon_idx], 24'h0});
  assign w0 = older[127:96] ^ t;
  assign w1 = older[95:64]  ^ w0;
  assign w2 = older[63:32]  ^ w1;
  assign w3 = older[31:0]   ^ w2;

  always_ff @(posedge clk) begin
    if (rst || wipe) begin
      cnt        <= '0;
      rcon_idx   <= '0;
      keys_valid <= 1'b0;
      rk_data    <= '0;
      for (int i = 0; i <= NR; i++) key_out[i] <= '0;
    end else begin
      rk_data <= (rk_addr > 4'(NR)) ? '0 : key_out[rk_addr];
      if (accept) begin
        key_out[0] <= key_in[255:128];
        key_out[1] <= key_in[127:0];
        cnt        <= 4'd2;
        rcon_idx   <= '0;
        keys_valid <= 1'b0;
      end else if (state_q == KS_EXPAND) begin
        key_out[cnt] <= {w0, w1, w2, w3};
        cnt          <= cnt + 4'd1;
        // Saturate so the final even slot leaves the index on the last rcon entry.
        if (!cnt[0] && rcon_idx != 3'd6) rcon_idx <= rcon_idx + 3'd1;
        if (cnt == 4'(NR)) keys_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Self-checking bench for aes_key_schedule_seq against a word-level FIPS-197 key expansion
// whose S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes_key_schedule_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key_out [0:14];
  logic         keys_valid;
  logic [3:0]   rk_addr;
  logic [127:0] rk_data;
`ifdef KEY_SCHED_ZEROIZE_EN
  logic         zeroize;
`endif

  int errors = 0;
  int checks = 0;

  logic [7:0]   sbox_ref [0:255];
  logic [127:0] ref_rk   [0:14];

  localparam logic [255:0] KEY_A3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  aes_key_schedule_seq dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_out    (key_out),
    .keys_valid (keys_valid),
    .rk_addr    (rk_addr),
    .rk_data    (rk_data)
`ifdef KEY_SCHED_ZEROIZE_EN
    ,
    .zeroize    (zeroize)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_math(input logic [7:0] a);
    logic [7:0] inv = 8'h00;
    if (a != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    end
    return inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox_ref[x[31:24]], sbox_ref[x[23:16]], sbox_ref[x[15:8]], sbox_ref[x[7:0]]};
  endfunction

  task automatic expand_ref(input logic [255:0] k);
    logic [31:0] w [0:59];
    logic [31:0] tmp;
    logic [7:0]  rc;
    for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = xt(rc);
      end else if (i % 8 == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-8] ^ tmp;
    end
    for (int r = 0; r < 15; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  task automatic check_cleared(input string tag);
    check({tag, "_ready"}, key_ready, 1);
    check({tag, "_keys_valid"}, keys_valid, 0);
    for (int r = 0; r < 15; r++) check($sformatf("%s_key_out%0d", tag, r), key_out[r], '0);
  endtask

  // Offer one key, optionally holding key_valid through expansion, then verify latency and all keys.
  task automatic run_key(input logic [255:0] k, input bit hold, input string tag);
    int n;
    key_in    = k;
    key_valid = 1'b1;
    step();
    check({tag, "_ready_after_accept"}, key_ready, 0);
    check({tag, "_kv_after_accept"}, keys_valid, 0);
    if (!hold) key_valid = 1'b0;
    n = 0;
    while (!keys_valid && n < 40) begin
      check($sformatf("%s_ready_expand%0d", tag, n), key_ready, 0);
      if (n == 12) key_valid = 1'b0;
      step();
      n++;
    end
    key_valid = 1'b0;
    check({tag, "_latency"}, n, 13);
    check({tag, "_ready_done"}, key_ready, 1);
    expand_ref(k);
    for (int r = 0; r < 15; r++) check($sformatf("%s_rk%0d", tag, r), key_out[r], ref_rk[r]);
  endtask

  task automatic check_a3_vectors();
    check("a3_rk2", key_out[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
    check("a3_rk3", key_out[3], 128'ha8b09c1a93d194cdbe49846eb75d5b9a);
    check("a3_rk14", key_out[14], 128'hfe4890d1e6188d0b046df344706c631e);
  endtask

  initial begin
    int a;
    for (int i = 0; i < 256; i++) sbox_ref[i] = sbox_math(8'(i));
    rst       = 1'b1;
    key_in    = '0;
    key_valid = 1'b0;
    rk_addr   = 4'd0;
`ifdef KEY_SCHED_ZEROIZE_EN
    zeroize   = 1'b0;
`endif
    step();
    step();
    rst = 1'b0;
    check_cleared("reset");
    check("reset_rk_data", rk_data, '0);

    // FIPS-197 A.3 with key_valid held across the expansion.
    run_key(KEY_A3, 1'b1, "a3");
    check_a3_vectors();
    step();
    check("a3_kv_stable", keys_valid, 1);

    // Read port.
    rk_addr = 4'd3;
    step();
    check("rd_addr3", rk_data, 128'ha8b09c1a93d194cdbe49846eb75d5b9a);
    rk_addr = 4'd15;
    step();
    check("rd_addr15", rk_data, '0);
    for (int i = 0; i < 8; i++) begin
      a = $urandom_range(0, 15);
      rk_addr = 4'(a);
      step();
      check($sformatf("rd_rand_addr%0d", a), rk_data, (a > 14) ? 128'h0 : ref_rk[a]);
    end

    // Restart from DONE with random keys.
    for (int i = 0; i < 4; i++) run_key(rand_key(), 1'b0, $sformatf("rnd%0d", i));

    // Reset mid-expansion at cnt=7, then a fresh run.
    key_in    = KEY_A3;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_cleared("midrst");
    check("midrst_rk_data", rk_data, '0);
    run_key(KEY_A3, 1'b0, "a3_again");
    check_a3_vectors();

`ifdef KEY_SCHED_ZEROIZE_EN
    zeroize = 1'b1;
    step();
    zeroize = 1'b0;
    check_cleared("zeroize");
    run_key(rand_key(), 1'b0, "pre_zacc");
    key_in    = KEY_A3;
    key_valid = 1'b1;
    zeroize   = 1'b1;
    step();
    key_valid = 1'b0;
    zeroize   = 1'b0;
    check_cleared("zero_vs_accept");
    step();
    check("zero_vs_accept_idle", key_ready, 1);
    check("zero_vs_accept_rk0", key_out[0], '0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
